// File: rtl/add_sat_pkg.sv
// Shared definitions for the lane-segmented saturating adder pipeline:
// saturation mode encodings and lane bit-position helpers.
package add_sat_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'd0;
  localparam logic [1:0] MODE_DELTA    = 2'd1;
  localparam logic [1:0] MODE_UNSIGNED = 2'd2;
  localparam logic [1:0] MODE_SIGNED   = 2'd3;

  // Absolute bit index of the most significant bit of a given lane.
  function automatic int lane_top_bit(input int lane, input int lw);
    return lane * lw + lw - 1;
  endfunction

endpackage

// File: rtl/add_sat_lane.sv
// One carry-select lane: produces the lane sum for carry-in 0 and carry-in 1.
module add_sat_lane #(
  parameter int LW = 8
) (
  input  logic [LW-1:0] a,
  input  logic [LW-1:0] b,
  output logic [LW-1:0] q_c0,
  output logic [LW-1:0] q_c1,
  output logic          co_c0,
  output logic          co_c1
);

  assign {co_c0, q_c0} = {1'b0, a} + {1'b0, b};
  assign {co_c1, q_c1} = {1'b0, a} + {1'b0, b} + {{LW{1'b0}}, 1'b1};

endmodule

// File: rtl/add_sat_pipe.sv
// Two-stage lane-segmented saturating adder with valid/ready flow control.
// Stage 1 captures carry-select lane sums; stage 2 resolves carries and clamps.
module add_sat_pipe
  import add_sat_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LW    = 8
) (
  input  logic                  sys_clk,
  input  logic                  resetl,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*LW-1:0]   a,
  input  logic [LANES*LW-1:0]   b,
  input  logic                  cin,
  input  logic [LANES-2:0]      chain,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*LW-1:0]   r,
  output logic                  co,
  output logic [LANES-1:0]      sat_lane,
  input  logic                  sat_clr,
  output logic                  sat_sticky
);

  localparam int W = LANES * LW;

  logic [W-1:0]     q_c0_s, q_c1_s;
  logic [LANES-1:0] co_c0_s, co_c1_s, a_top_s, b_top_s;

  logic [W-1:0]     s1_q0_r, s1_q1_r;
  logic [LANES-1:0] s1_c0_r, s1_c1_r, s1_atop_r, s1_btop_r;
  logic             s1_cin_r, s1_valid_r;
  logic [LANES-2:0] s1_chain_r;
  logic [1:0]       s1_mode_r;

  logic             s1_load_s, s2_load_s;
  logic [LANES-1:0] chain_lo_s, chain_hi_s, lane_cout_s, sat_next_s;
  logic [W-1:0]     sum_s, r_next_s;
  logic [LW-1:0]    clamp_s;
  logic             lane_cin_s, carry_run_s, is_top_s, ovf_here_s;
  logic             seg_ovf_s, seg_carry_s, seg_atop_s;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    add_sat_lane #(.LW(LW)) u_lane (
      .a     (a[i*LW +: LW]),
      .b     (b[i*LW +: LW]),
      .q_c0  (q_c0_s[i*LW +: LW]),
      .q_c1  (q_c1_s[i*LW +: LW]),
      .co_c0 (co_c0_s[i]),
      .co_c1 (co_c1_s[i])
    );
    assign a_top_s[i] = a[lane_top_bit(i, LW)];
    assign b_top_s[i] = b[lane_top_bit(i, LW)];
  end

  assign s2_load_s = !out_valid || out_ready;
  assign s1_load_s = !s1_valid_r || s2_load_s;
  assign in_ready  = s1_load_s;

  // chain_lo[i]: lane i takes carry from below; chain_hi[i]: lane i is not a segment top
  assign chain_lo_s = {s1_chain_r, 1'b0};
  assign chain_hi_s = {1'b0, s1_chain_r};

  // Stage 1: capture lane sums, top bits and per-beat control
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      s1_valid_r <= 1'b0;
      s1_q0_r    <= '0;
      s1_q1_r    <= '0;
      s1_c0_r    <= '0;
      s1_c1_r    <= '0;
      s1_atop_r  <= '0;
      s1_btop_r  <= '0;
      s1_cin_r   <= 1'b0;
      s1_chain_r <= '0;
      s1_mode_r  <= MODE_WRAP;
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      s1_q0_r    <= q_c0_s;
      s1_q1_r    <= q_c1_s;
      s1_c0_r    <= co_c0_s;
      s1_c1_r    <= co_c1_s;
      s1_atop_r  <= a_top_s;
      s1_btop_r  <= b_top_s;
      s1_cin_r   <= cin;
      s1_chain_r <= chain;
      s1_mode_r  <= mode;
    end
  end

  // Carry resolution: each segment bottom restarts from cin, others ripple the selected carry
  always_comb begin
    sum_s       = '0;
    lane_cout_s = '0;
    lane_cin_s  = 1'b0;
    carry_run_s = s1_cin_r;
    for (int i = 0; i < LANES; i++) begin
      lane_cin_s = chain_lo_s[i] ? carry_run_s : s1_cin_r;
      if (lane_cin_s) begin
        sum_s[i*LW +: LW] = s1_q1_r[i*LW +: LW];
        lane_cout_s[i]    = s1_c1_r[i];
      end else begin
        sum_s[i*LW +: LW] = s1_q0_r[i*LW +: LW];
        lane_cout_s[i]    = s1_c0_r[i];
      end
      carry_run_s = lane_cout_s[i];
    end
  end

  // Segment saturation: walk downward so each lane inherits its segment top's verdict
  always_comb begin
    r_next_s    = sum_s;
    sat_next_s  = '0;
    seg_ovf_s   = 1'b0;
    seg_carry_s = 1'b0;
    seg_atop_s  = 1'b0;
    is_top_s    = 1'b0;
    ovf_here_s  = 1'b0;
    clamp_s     = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      is_top_s = !chain_hi_s[i];
      case (s1_mode_r)
        MODE_DELTA:    ovf_here_s = s1_btop_r[i] ^ lane_cout_s[i];
        MODE_UNSIGNED: ovf_here_s = lane_cout_s[i];
        MODE_SIGNED:   ovf_here_s = (s1_atop_r[i] == s1_btop_r[i]) &&
                                    (sum_s[lane_top_bit(i, LW)] != s1_atop_r[i]);
        default:       ovf_here_s = 1'b0;
      endcase
      seg_ovf_s   = is_top_s ? ovf_here_s     : seg_ovf_s;
      seg_carry_s = is_top_s ? lane_cout_s[i] : seg_carry_s;
      seg_atop_s  = is_top_s ? s1_atop_r[i]   : seg_atop_s;
      case (s1_mode_r)
        MODE_DELTA:    clamp_s = {LW{seg_carry_s}};
        MODE_UNSIGNED: clamp_s = {LW{1'b1}};
        MODE_SIGNED:   clamp_s = is_top_s ? {seg_atop_s, {(LW-1){~seg_atop_s}}}
                                          : {LW{~seg_atop_s}};
        default:       clamp_s = sum_s[i*LW +: LW];
      endcase
      if (seg_ovf_s) begin
        r_next_s[i*LW +: LW] = clamp_s;
        sat_next_s[i]        = 1'b1;
      end else begin
        r_next_s[i*LW +: LW] = sum_s[i*LW +: LW];
        sat_next_s[i]        = 1'b0;
      end
    end
  end

  // Stage 2: registered result, holds while the consumer stalls
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      out_valid <= 1'b0;
      r         <= '0;
      co        <= 1'b0;
      sat_lane  <= '0;
    end else if (s2_load_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        r        <= r_next_s;
        co       <= lane_cout_s[LANES-1];
        sat_lane <= sat_next_s;
      end
    end
  end

  // Sticky saturation status; a saturating transfer beats a simultaneous clear
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      sat_sticky <= 1'b0;
    end else if (out_valid && out_ready && (|sat_lane)) begin
      sat_sticky <= 1'b1;
    end else if (sat_clr) begin
      sat_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_sat_pipe.sv
// Directed self-checking bench for add_sat_pipe with LANES=4, LW=8.
module tb_add_sat_pipe;

  logic        sys_clk = 1'b0;
  logic        resetl;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        cin;
  logic [2:0]  chain;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] r;
  logic        co;
  logic [3:0]  sat_lane;
  logic        sat_clr;
  logic        sat_sticky;

  int checks   = 0;
  int failures = 0;

  add_sat_pipe #(.LANES(4), .LW(8)) dut (
    .sys_clk    (sys_clk),
    .resetl     (resetl),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .chain      (chain),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .r          (r),
    .co         (co),
    .sat_lane   (sat_lane),
    .sat_clr    (sat_clr),
    .sat_sticky (sat_sticky)
  );

  always #5 sys_clk = ~sys_clk;

  // Push one beat into an empty pipe and capture the result when it appears.
  task automatic run_beat(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                          input logic [2:0] ch, input logic [1:0] md,
                          output logic [31:0] rv, output logic cov, output logic [3:0] sv);
    int n;
    @(negedge sys_clk);
    a = av; b = bv; cin = cv; chain = ch; mode = md;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge sys_clk);
    while (!out_valid && n < 8) begin
      @(negedge sys_clk);
      n++;
    end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL beat_timeout: out_valid=%b required 1", out_valid);
    end
    rv = r; cov = co; sv = sat_lane;
    @(posedge sys_clk); #1;
  endtask

  task automatic pulse_clear();
    @(negedge sys_clk);
    sat_clr = 1'b1;
    @(posedge sys_clk); #1;
    sat_clr = 1'b0;
  endtask

  task automatic test_reset();
    resetl = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    a = '0; b = '0; cin = 1'b0; chain = '0; mode = 2'd0;
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rst_r: got %h want 0", r); end
    checks++; if (co !== 1'b0) begin failures++; $display("FAIL rst_co: got %b want 0", co); end
    checks++; if (sat_lane !== 4'b0000) begin failures++; $display("FAIL rst_sat_lane: got %b want 0000", sat_lane); end
    checks++; if (sat_sticky !== 1'b0) begin failures++; $display("FAIL rst_sticky: got %b want 0", sat_sticky); end
    @(negedge sys_clk);
    resetl = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_delta();
    logic [31:0] rv; logic cv; logic [3:0] sv;
    run_beat(32'h000000F0, 32'hFFFFFFE0, 1'b0, 3'b111, 2'd1, rv, cv, sv);
    checks++; if (rv !== 32'h000000D0) begin failures++; $display("FAIL delta1_r: got %h want 000000d0", rv); end
    checks++; if (sv !== 4'b0000) begin failures++; $display("FAIL delta1_sat: got %b want 0000", sv); end
    run_beat(32'h00000010, 32'hFFFFFFE0, 1'b0, 3'b111, 2'd1, rv, cv, sv);
    checks++; if (rv !== 32'h00000000) begin failures++; $display("FAIL delta2_r: got %h want 00000000", rv); end
    checks++; if (sv !== 4'b1111) begin failures++; $display("FAIL delta2_sat: got %b want 1111", sv); end
  endtask

  task automatic test_unsigned();
    logic [31:0] rv; logic cv; logic [3:0] sv;
    run_beat(32'hFF108001, 32'h02208001, 1'b0, 3'b000, 2'd2, rv, cv, sv);
    checks++; if (rv !== 32'hFF30FF02) begin failures++; $display("FAIL uns_r: got %h want ff30ff02", rv); end
    checks++; if (sv !== 4'b1010) begin failures++; $display("FAIL uns_sat: got %b want 1010", sv); end
    checks++; if (cv !== 1'b1) begin failures++; $display("FAIL uns_co: got %b want 1", cv); end
  endtask

  task automatic test_signed();
    logic [31:0] rv; logic cv; logic [3:0] sv;
    pulse_clear();
    checks++; if (sat_sticky !== 1'b0) begin failures++; $display("FAIL sgn_clear: got %b want 0", sat_sticky); end
    run_beat(32'h7FFF8000, 32'h0001FFFF, 1'b0, 3'b101, 2'd3, rv, cv, sv);
    checks++; if (rv !== 32'h7FFF8000) begin failures++; $display("FAIL sgn_r: got %h want 7fff8000", rv); end
    checks++; if (sv !== 4'b1111) begin failures++; $display("FAIL sgn_sat: got %b want 1111", sv); end
    checks++; if (sat_sticky !== 1'b1) begin failures++; $display("FAIL sgn_sticky: got %b want 1", sat_sticky); end
  endtask

  task automatic test_wrap();
    logic [31:0] rv; logic cv; logic [3:0] sv;
    pulse_clear();
    run_beat(32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b111, 2'd0, rv, cv, sv);
    checks++; if (rv !== 32'h00000000) begin failures++; $display("FAIL wrap_r: got %h want 00000000", rv); end
    checks++; if (cv !== 1'b1) begin failures++; $display("FAIL wrap_co: got %b want 1", cv); end
    checks++; if (sv !== 4'b0000) begin failures++; $display("FAIL wrap_sat: got %b want 0000", sv); end
    checks++; if (sat_sticky !== 1'b0) begin failures++; $display("FAIL wrap_sticky: got %b want 0", sat_sticky); end
  endtask

  task automatic test_back_pressure();
    logic [31:0] bp_a [4];
    logic [31:0] bp_b [4];
    logic [31:0] bp_exp [4];
    logic [31:0] held;
    int sent, got, changes;
    bp_a   = '{32'h11223344, 32'h80000001, 32'hFFFFFFFF, 32'h12345678};
    bp_b   = '{32'h01010101, 32'h80000001, 32'h00000002, 32'h11111111};
    bp_exp = '{32'h12233445, 32'h00000002, 32'h00000001, 32'h23456789};
    sent = 0; got = 0; changes = 0; held = '0;
    cin = 1'b0; chain = 3'b111; mode = 2'd0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge sys_clk);
      out_ready = (cyc >= 5);
      if (out_valid && !out_ready) begin
        if (cyc > 2 && r !== held) changes++;
        held = r;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (got >= 4) begin
          failures++; $display("FAIL bp_extra: got extra result %h", r);
        end else if (r !== bp_exp[got]) begin
          failures++; $display("FAIL bp_result%0d: got %h want %h", got, r, bp_exp[got]);
        end
        got++;
      end
      if (sent < 4) begin
        in_valid = 1'b1; a = bp_a[sent]; b = bp_b[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 4) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        checks++; if (sent !== 2) begin failures++; $display("FAIL bp_held: got %0d beats want 2", sent); end
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++; if (got !== 4) begin failures++; $display("FAIL bp_count: got %0d results want 4", got); end
    checks++; if (changes !== 0) begin failures++; $display("FAIL bp_stable: r changed %0d times want 0", changes); end
  endtask

  task automatic test_sticky_race();
    int n;
    pulse_clear();
    checks++; if (sat_sticky !== 1'b0) begin failures++; $display("FAIL race_pre: got %b want 0", sat_sticky); end
    @(negedge sys_clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b0; chain = 3'b000; mode = 2'd2;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge sys_clk); #1;
    in_valid = 1'b0;
    n = 0;
    @(negedge sys_clk);
    while (!out_valid && n < 8) begin
      @(negedge sys_clk);
      n++;
    end
    checks++; if (sat_lane !== 4'b1111) begin failures++; $display("FAIL race_sat: got %b want 1111", sat_lane); end
    sat_clr = 1'b1;
    @(posedge sys_clk); #1;
    sat_clr = 1'b0;
    checks++; if (sat_sticky !== 1'b1) begin failures++; $display("FAIL race_sticky: got %b want 1", sat_sticky); end
  endtask

  task automatic test_reset_race();
    @(negedge sys_clk);
    out_ready = 1'b0;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b0; chain = 3'b000; mode = 2'd2;
    in_valid = 1'b1;
    @(negedge sys_clk);
    a = 32'h80808080; b = 32'h80808080;
    @(negedge sys_clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rr_pre_valid: got %b want 1", out_valid); end
    #2;
    resetl = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_out_valid: got %b want 0", out_valid); end
    checks++; if (sat_sticky !== 1'b0) begin failures++; $display("FAIL rr_sticky: got %b want 0", sat_sticky); end
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rr_r: got %h want 0", r); end
    checks++; if (sat_lane !== 4'b0000) begin failures++; $display("FAIL rr_sat: got %b want 0000", sat_lane); end
    @(negedge sys_clk);
    resetl = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_ghost: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_delta();
    test_unsigned();
    test_signed();
    test_wrap();
    test_back_pressure();
    test_sticky_race();
    test_reset_race();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
